// File: rtl/rv32i_wb_arbiter.sv
// ============================================================================
//  Module   : rv32i_wb_arbiter
//  Brief    : Per-source result FIFOs feeding a round-robin arbiter that
//             serializes completed results onto the registered write-back bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_wb_arbiter #(
    parameter int NUM_SRC              = 2,
    parameter int BUF_DEPTH            = 2,
    parameter int PHYS_REG_FILE_IDX_BW = 6,
    parameter int REG_FILE_BW          = 32,
    parameter int ROB_DEPTH            = 16
) (
    input  logic                                              clk,
    input  logic                                              rstn,
    input  logic [NUM_SRC-1:0]                                i_res_vld,
    input  logic [NUM_SRC-1:0][PHYS_REG_FILE_IDX_BW-1:0]      i_res_phys_rf_tag,
    input  logic [NUM_SRC-1:0][REG_FILE_BW-1:0]               i_res_wdata,
    input  logic [NUM_SRC-1:0][$clog2(ROB_DEPTH)-1:0]         i_res_rob_entry_idx,
    output logic [NUM_SRC-1:0]                                o_res_rdy,
    output logic                                              o_write_back,
    output logic [PHYS_REG_FILE_IDX_BW-1:0]                   o_phys_rf_wr_idx,
    output logic [REG_FILE_BW-1:0]                            o_wdata,
    output logic [$clog2(ROB_DEPTH)-1:0]                      o_rob_entry_idx
);

    localparam int TAG_W = PHYS_REG_FILE_IDX_BW;
    localparam int DAT_W = REG_FILE_BW;
    localparam int ROB_W = $clog2(ROB_DEPTH);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_gnt_vld;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W-1:0]   w_idx_sel;
    int                 w_idx;
    logic [SRC_W-1:0]   r_rr_ptr;

    logic [TAG_W-1:0]   w_head_tag [NUM_SRC];
    logic [DAT_W-1:0]   w_head_dat [NUM_SRC];
    logic [ROB_W-1:0]   w_head_rob [NUM_SRC];

    logic [TAG_W-1:0]   w_sel_tag;
    logic [DAT_W-1:0]   w_sel_dat;
    logic [ROB_W-1:0]   w_sel_rob;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [TAG_W-1:0] r_tag_mem [BUF_DEPTH];
        logic [DAT_W-1:0] r_dat_mem [BUF_DEPTH];
        logic [ROB_W-1:0] r_rob_mem [BUF_DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_count;
        logic             w_push;

        // Ready looks only at occupancy, so a full buffer never pushes and pops together.
        assign o_res_rdy[s] = (r_count < CNT_W'(BUF_DEPTH));
        assign w_req[s]     = (r_count != '0);
        assign w_push       = i_res_vld[s] & o_res_rdy[s];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_pop[s]) begin
                    r_rd_ptr <= (r_rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop[s]) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop[s]) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= i_res_phys_rf_tag[s];
                r_dat_mem[r_wr_ptr] <= i_res_wdata[s];
                r_rob_mem[r_wr_ptr] <= i_res_rob_entry_idx[s];
            end
        end

        assign w_head_tag[s] = r_tag_mem[r_rd_ptr];
        assign w_head_dat[s] = r_dat_mem[r_rd_ptr];
        assign w_head_rob[s] = r_rob_mem[r_rd_ptr];
    end

    // Walk from the highest offset down so the lowest offset past rr_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        w_idx_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_idx     = (int'(r_rr_ptr) + i) % NUM_SRC;
            w_idx_sel = w_idx[SRC_W-1:0];
            if (w_req[w_idx_sel]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx_sel;
            end
        end
    end

    always_comb begin
        w_pop     = '0;
        w_sel_tag = '0;
        w_sel_dat = '0;
        w_sel_rob = '0;
        if (w_gnt_vld) begin
            w_pop[w_gnt_idx] = 1'b1;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_gnt_idx == SRC_W'(s)) begin
                w_sel_tag = w_head_tag[s];
                w_sel_dat = w_head_dat[s];
                w_sel_rob = w_head_rob[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr         <= '0;
            o_write_back     <= 1'b0;
            o_phys_rf_wr_idx <= '0;
            o_wdata          <= '0;
            o_rob_entry_idx  <= '0;
        end else begin
            o_write_back <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr_ptr         <= (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
                o_phys_rf_wr_idx <= w_sel_tag;
                o_wdata          <= w_sel_dat;
                o_rob_entry_idx  <= w_sel_rob;
            end
        end
    end

endmodule

`default_nettype wire
